// File: rtl/seq_pkg.sv
// Shared state encoding and default widths for the MPU command sequencer.
package seq_pkg;

   localparam int STATE_W         = 6;
   localparam int DEF_ADDR_ROM_SZ = 4;
   localparam int DEF_ADDR_OPM_SZ = 4;
   localparam int DEF_DATA_OPM_SZ = 16;
   localparam int TMO_W           = 20;

   // One-hot: any other pattern is treated as a corrupted state.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 6'b000001,
      ST_FETCH = 6'b000010,
      ST_ISSUE = 6'b000100,
      ST_WAIT  = 6'b001000,
      ST_STORE = 6'b010000,
      ST_NEXT  = 6'b100000
   } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog: counts while enabled, restarts on clear, flags expiry on the
// TMO_CYC-th enabled cycle.
module seq_watchdog
   import seq_pkg::*;
#(
   parameter logic [TMO_W-1:0] TMO_CYC = 20'd500_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TMO_W-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (RST || clear) begin
         r_cnt <= '0;
      end else if (enable && !expired) begin
         r_cnt <= r_cnt + TMO_W'(1);
      end
   end

   assign expired = enable && (r_cnt >= TMO_CYC - TMO_W'(1));

endmodule

// File: rtl/mpu_sequencer.sv
// Walks the command ROM, hands each command to the controller and stores read
// results in the OPM. Define SEQ_LOOP_EN to keep polling while I_START is high.
module mpu_sequencer
   import seq_pkg::*;
#(
   parameter int                     ADDR_ROM_SZ = DEF_ADDR_ROM_SZ,
   parameter int                     ADDR_OPM_SZ = DEF_ADDR_OPM_SZ,
   parameter int                     DATA_OPM_SZ = DEF_DATA_OPM_SZ,
   parameter int                     RXD_SZ      = 24,
   parameter logic [ADDR_ROM_SZ-1:0] LAST_CMD    = 4'd9,
   parameter logic [ADDR_ROM_SZ-1:0] LOOP_ADDR   = 4'd3,
   parameter logic [TMO_W-1:0]       TMO_CYC     = 20'd500_000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   I_START,
   input  logic                   I_CTRL_BUSY,
   input  logic [1:0]             I_CTRL_FL,
   input  logic                   I_CTRL_ERR,
   input  logic [RXD_SZ-1:0]      I_RXD_BUFF,
   output logic [ADDR_ROM_SZ-1:0] O_ADDR_ROM,
   output logic                   O_EN_CTRL,
   output logic                   O_WE_OPM,
   output logic [ADDR_OPM_SZ-1:0] O_ADDR_OPM,
   output logic [DATA_OPM_SZ-1:0] O_DATA_OPM,
   output logic                   O_BUSY,
   output logic                   O_DONE,
   output logic                   O_ERR
);

   seq_state_e             r_state;
   seq_state_e             w_next;
   logic [ADDR_ROM_SZ-1:0] r_addr_rom;
   logic [ADDR_OPM_SZ-1:0] r_addr_opm;
   logic                   r_rd;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;
   logic                   w_last;
   logic                   w_expired;
   logic                   w_fault;
   logic                   w_wd_clear;
   logic                   w_wd_enable;
   logic                   w_unused;

   assign w_last      = (r_addr_rom == LAST_CMD);
   assign w_wd_enable = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign w_wd_clear  = (w_next != r_state) && ((w_next == ST_ISSUE) || (w_next == ST_WAIT));
   // Timeout and controller error share one path, so coincident events count once.
   assign w_fault     = (r_state != ST_IDLE) && (I_CTRL_ERR || w_expired);

   seq_watchdog #(.TMO_CYC(TMO_CYC)) u_watchdog (
      .CLK     (CLK),
      .RST     (RST),
      .clear   (w_wd_clear),
      .enable  (w_wd_enable),
      .expired (w_expired)
   );

   always_ff @(posedge CLK) begin
      if (RST) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (I_START) w_next = ST_FETCH;
         ST_FETCH: w_next = ST_ISSUE;
         ST_ISSUE: if (I_CTRL_BUSY) w_next = ST_WAIT;
         ST_WAIT:  if (!I_CTRL_BUSY) w_next = r_rd ? ST_STORE : ST_NEXT;
         ST_STORE: w_next = ST_NEXT;
`ifdef SEQ_LOOP_EN
         ST_NEXT:  w_next = (w_last && !I_START) ? ST_IDLE : ST_FETCH;
`else
         ST_NEXT:  w_next = w_last ? ST_IDLE : ST_FETCH;
`endif
         default:  w_next = ST_IDLE;
      endcase
      if (w_fault) w_next = ST_IDLE;
   end

   always_comb begin
      O_EN_CTRL  = 1'b0;
      O_WE_OPM   = 1'b0;
      O_DATA_OPM = '0;
      if (r_state == ST_ISSUE) O_EN_CTRL = 1'b1;
      if (r_state == ST_STORE) begin
         O_WE_OPM   = 1'b1;
         O_DATA_OPM = I_RXD_BUFF[DATA_OPM_SZ-1:0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_addr_rom <= '0;
         r_addr_opm <= '0;
         r_rd       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_fault) begin
         r_busy <= 1'b0;
         r_err  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: if (I_START) begin
               r_addr_rom <= '0;
               r_addr_opm <= '0;
               r_busy     <= 1'b1;
               r_done     <= 1'b0;
               r_err      <= 1'b0;
            end
            ST_ISSUE: if (I_CTRL_BUSY) r_rd <= I_CTRL_FL[0];
            ST_STORE: r_addr_opm <= r_addr_opm + ADDR_OPM_SZ'(1);
            ST_NEXT: begin
               if (!w_last) begin
                  r_addr_rom <= r_addr_rom + ADDR_ROM_SZ'(1);
`ifdef SEQ_LOOP_EN
               end else if (I_START) begin
                  r_addr_rom <= LOOP_ADDR;
                  r_addr_opm <= '0;
`endif
               end else begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
               end
            end
            ST_FETCH, ST_WAIT: begin
            end
            default: begin
               r_busy <= 1'b0;
               r_err  <= 1'b1;
            end
         endcase
      end
   end

   assign O_ADDR_ROM = r_addr_rom;
   assign O_ADDR_OPM = r_addr_opm;
   assign O_BUSY     = r_busy;
   assign O_DONE     = r_done;
   assign O_ERR      = r_err;

`ifdef SEQ_LOOP_EN
   assign w_unused = &{1'b0, I_CTRL_FL[1], I_RXD_BUFF[RXD_SZ-1:DATA_OPM_SZ]};
`else
   assign w_unused = &{1'b0, I_CTRL_FL[1], I_RXD_BUFF[RXD_SZ-1:DATA_OPM_SZ], LOOP_ADDR};
`endif

endmodule

// File: tb/tb_mpu_sequencer.sv
// Bench for mpu_sequencer: controller responder, table-driven sequence model,
// write/ROM scoreboard. Define SEQ_LOOP_EN to run the loop-mode scenario.
module tb_mpu_sequencer;

   localparam int LAST  = 2;
   localparam int LOOPA = 1;
   localparam int TMO   = 100;

   logic        clk;
   logic        rst;
   logic        start;
   logic        ctrl_busy;
   logic [1:0]  ctrl_fl;
   logic        ctrl_err;
   logic [23:0] rxd;
   logic [3:0]  o_addr_rom;
   logic        o_en_ctrl;
   logic        o_we_opm;
   logic [3:0]  o_addr_opm;
   logic [15:0] o_data_opm;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   bit          cmd_rd   [0:15];
   logic [15:0] data_tbl [0:15];
   int          delay_tbl[0:15];
   int          blen_tbl [0:15];
   bit          stuck;
   bit          rand_hi;
   bit          resp_act;
   logic [19:0] exp_q[$];
   logic [3:0]  rom_q[$];
   int          n_vec;
   int          n_err;
   int          en_rises;
   int          last_en_len;
   int          n_writes;

   mpu_sequencer #(
      .LAST_CMD  (4'd2),
      .LOOP_ADDR (4'd1),
      .TMO_CYC   (20'd100)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .I_START     (start),
      .I_CTRL_BUSY (ctrl_busy),
      .I_CTRL_FL   (ctrl_fl),
      .I_CTRL_ERR  (ctrl_err),
      .I_RXD_BUFF  (rxd),
      .O_ADDR_ROM  (o_addr_rom),
      .O_EN_CTRL   (o_en_ctrl),
      .O_WE_OPM    (o_we_opm),
      .O_ADDR_OPM  (o_addr_opm),
      .O_DATA_OPM  (o_data_opm),
      .O_BUSY      (o_busy),
      .O_DONE      (o_done),
      .O_ERR       (o_err)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- controller responder ----------------
   initial begin : responder
      int a;
      ctrl_busy = 1'b0;
      ctrl_fl   = 2'b00;
      rxd       = '0;
      resp_act  = 1'b0;
      forever begin
         @(negedge clk);
         if (o_en_ctrl && !stuck) begin
            resp_act = 1'b1;
            a = int'(o_addr_rom);
            repeat (delay_tbl[a] - 1) @(negedge clk);
            ctrl_fl   = cmd_rd[a] ? 2'b01 : 2'b10;
            ctrl_busy = 1'b1;
            repeat (blen_tbl[a]) @(negedge clk);
            ctrl_busy = 1'b0;
            ctrl_fl   = 2'b00;
            rxd       = {(rand_hi ? 8'($urandom) : 8'h00), data_tbl[a]};
            resp_act  = 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic        en_prev;
      int          run;
      logic [19:0] want;
      en_prev = 1'b0;
      run = 0;
      en_rises = 0;
      last_en_len = 0;
      n_writes = 0;
      forever begin
         @(negedge clk);
         if (o_en_ctrl) begin
            if (!en_prev) begin
               en_rises++;
               run = 1;
               if (rom_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL rom_unexpected_issue: got addr %0d, expected no issue", o_addr_rom);
               end else begin
                  check("rom_addr_seq", 32'(o_addr_rom), 32'(rom_q.pop_front()));
               end
            end else begin
               run++;
            end
         end else if (en_prev) begin
            last_en_len = run;
         end
         en_prev = o_en_ctrl;
         if (o_we_opm) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL opm_unexpected_write: got addr %0d data 0x%0h, expected no write", o_addr_opm, o_data_opm);
            end else begin
               want = exp_q.pop_front();
               check("opm_write", 32'({o_addr_opm, o_data_opm}), 32'(want));
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // A pass visits ROM 0..LAST (loop passes start at LOOPA); each read command
   // lands at the next OPM slot, counted from 0 at the start of every pass.
   task automatic build_expect(input int passes, output int opm_end);
      int k;
      int first;
      k = 0;
      for (int p = 0; p < passes; p++) begin
         k = 0;
         first = (p == 0) ? 0 : LOOPA;
         for (int a = first; a <= LAST; a++) begin
            rom_q.push_back(4'(a));
            if (cmd_rd[a]) begin
               exp_q.push_back({4'(k), data_tbl[a]});
               k = (k + 1) % 16;
            end
         end
      end
      opm_end = k;
   endtask

   task automatic rand_tables();
      for (int a = 0; a < 16; a++) begin
         cmd_rd[a]    = bit'($urandom_range(0, 1));
         data_tbl[a]  = 16'($urandom);
         delay_tbl[a] = $urandom_range(1, 4);
         blen_tbl[a]  = $urandom_range(1, 12);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_end(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (o_done || o_err) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_ctrl_busy(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (ctrl_busy) seen = 1'b1;
      end
      check(name, 32'(seen), 32'd1);
   endtask

   task automatic wait_resp_idle();
      for (int i = 0; i < 200 && resp_act; i++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_pass_end(input string tag, input int exp_opm);
      check({tag, "_done"}, 32'(o_done), 32'd1);
      check({tag, "_err"}, 32'(o_err), 32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_rom_end"}, 32'(o_addr_rom), 32'(LAST));
      check({tag, "_opm_end"}, 32'(o_addr_opm), 32'(exp_opm));
      check({tag, "_queues_empty"}, 32'(exp_q.size() + rom_q.size()), 32'd0);
   endtask

   task automatic run_pass(input string tag, input int exp_opm);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end({tag, "_finish"});
      check_pass_end(tag, exp_opm);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs_zero"},
            32'({o_addr_rom, o_en_ctrl, o_we_opm, o_addr_opm, o_data_opm, o_busy, o_done, o_err}),
            32'd0);
   endtask

   // ---------------- main stimulus ----------------
   initial begin : main
      int opm_end;
      int w0;
      int base;
      bit hit;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      start = 1'b0;
      ctrl_err = 1'b0;
      stuck = 1'b0;
      rand_hi = 1'b1;
      rand_tables();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      check("reset_busy", 32'(o_busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed single pass: W, R, R with a 40-cycle busy controller.
      for (int a = 0; a < 16; a++) begin
         delay_tbl[a] = 2;
         blen_tbl[a]  = 40;
      end
      cmd_rd[0] = 1'b0;
      cmd_rd[1] = 1'b1;
      cmd_rd[2] = 1'b1;
      data_tbl[1] = 16'h1234;
      data_tbl[2] = 16'h5678;
      rand_hi = 1'b0;
      rom_q.push_back(4'd0);
      rom_q.push_back(4'd1);
      rom_q.push_back(4'd2);
      exp_q.push_back({4'd0, 16'h1234});
      exp_q.push_back({4'd1, 16'h5678});
      w0 = n_writes;
      run_pass("single", 2);
      check("single_write_count", 32'(n_writes - w0), 32'd2);
      rand_hi = 1'b1;

      // Enable handshake: busy answers 3 cycles after enable.
      rand_tables();
      for (int a = 0; a < 16; a++) begin
         delay_tbl[a] = 3;
         blen_tbl[a]  = 2;
      end
      build_expect(1, opm_end);
      run_pass("handshake", opm_end);
      check("handshake_en_len", 32'(last_en_len), 32'd3);

      // Randomized passes.
      for (int p = 0; p < 6; p++) begin
         rand_tables();
         build_expect(1, opm_end);
         run_pass("random", opm_end);
      end

      // Timeout: controller never answers.
      stuck = 1'b1;
      rom_q.push_back(4'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_end("timeout_finish");
      @(negedge clk);
      check("timeout_err", 32'(o_err), 32'd1);
      check("timeout_busy", 32'(o_busy), 32'd0);
      check("timeout_en", 32'(o_en_ctrl), 32'd0);
      check("timeout_done", 32'(o_done), 32'd0);
      check("timeout_en_len", 32'(last_en_len), 32'(TMO));
      stuck = 1'b0;

      // Controller error pulse during WAIT on a read command.
      rand_tables();
      for (int a = 0; a < 16; a++) begin
         cmd_rd[a] = 1'b1;
         delay_tbl[a] = 1;
         blen_tbl[a] = 20;
      end
      rom_q.push_back(4'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ctrl_busy("ctrlerr_busy_seen");
      @(negedge clk);
      ctrl_err = 1'b1;
      @(negedge clk);
      ctrl_err = 1'b0;
      check("ctrlerr_err", 32'(o_err), 32'd1);
      check("ctrlerr_busy", 32'(o_busy), 32'd0);
      check("ctrlerr_en", 32'(o_en_ctrl), 32'd0);
      wait_resp_idle();
      check("ctrlerr_opm_addr", 32'(o_addr_opm), 32'd0);
      check("ctrlerr_queues_empty", 32'(exp_q.size() + rom_q.size()), 32'd0);

      // Reset in the middle of WAIT, then a clean rerun from ROM 0.
      for (int a = 0; a < 16; a++) cmd_rd[a] = 1'b0;
      rom_q.push_back(4'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_ctrl_busy("rstwait_busy_seen");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("rstwait");
      rst = 1'b0;
      wait_resp_idle();
      check_all_zero("rstwait_idle");
      rand_tables();
      build_expect(1, opm_end);
      run_pass("rerun", opm_end);

`ifdef SEQ_LOOP_EN
      // Loop mode: start held for three passes, dropped during the third.
      rand_tables();
      build_expect(3, opm_end);
      base = en_rises;
      hit = 1'b0;
      start = 1'b1;
      for (int i = 0; i < 3000 && !hit; i++) begin
         @(negedge clk);
         if (en_rises >= base + 6) hit = 1'b1;
      end
      check("loop_third_pass_seen", 32'(hit), 32'd1);
      check("loop_no_early_done", 32'(o_done), 32'd0);
      start = 1'b0;
      wait_end("loop_finish");
      check_pass_end("loop", opm_end);
`else
      // Single-pass mode: start held through completion restarts immediately.
      rand_tables();
      build_expect(1, opm_end);
      build_expect(1, opm_end);
      base = 0;
      hit = 1'b0;
      start = 1'b1;
      @(negedge clk);
      wait_end("restart_first_finish");
      check("restart_done", 32'(o_done), 32'd1);
      check("restart_busy_low", 32'(o_busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      check("restart_busy_again", 32'(o_busy), 32'd1);
      check("restart_done_clear", 32'(o_done), 32'd0);
      wait_end("restart_second_finish");
      check_pass_end("restart", opm_end);
`endif

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
